// File: rtl/port_alloc_rr.sv
// -----------------------------------------------------------------------------
// port_alloc_rr
//   Per-router output-port allocator. Each of the five inputs asks for one
//   output gate. Every output has a round-robin arbiter. The arbiter locks its
//   winner until that input fires its tail flit. The five owner registers feed
//   the grant-check stage. IDLE_SRC means the output is free.
//
//   Optional feature: define ALLOC_TIMEOUT_EN to turn on a per-output idle-lock
//   timer. The timer force-releases a lock after TIMEOUT enabled cycles in
//   which the owner moved no flit.
//
// Ports
//   clk, rst_n     clock (rising edge) and async active-low reset
//   enable         state-advance enable; when low, all state holds
//   req_valid[5]   input i has a pending flit
//   req_gate[15]   3-bit requested gate per input (0 ip,1 N,2 S,3 E,4 W)
//   req_tail[5]    pending flit of input i is a tail
//   in_fire[5]     flit of input i transferred this cycle
//   *_source[4]    owner input index per output, IDLE_SRC if free
//   in_granted[5]  input i owns the gate it currently requests (combinational)
//   gate_err       one-cycle pulse: a valid request named gate 5-7
// -----------------------------------------------------------------------------
module port_alloc_rr #(
    parameter int unsigned         SRC_W    = 4,
    parameter logic [SRC_W-1:0]    IDLE_SRC = SRC_W'(4'hf),
    parameter int unsigned         TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [4:0]       req_valid,
    input  logic [14:0]      req_gate,
    input  logic [4:0]       req_tail,
    input  logic [4:0]       in_fire,
    output logic [SRC_W-1:0] ip_source,
    output logic [SRC_W-1:0] north_source,
    output logic [SRC_W-1:0] south_source,
    output logic [SRC_W-1:0] east_source,
    output logic [SRC_W-1:0] west_source,
    output logic [4:0]       in_granted,
    output logic             gate_err
);

    localparam int unsigned N_PORT = 5;
    localparam int unsigned GATE_W = 3;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned CNT_W  = 5;

    logic [SRC_W-1:0]  owner_q [N_PORT];
    logic [SRC_W-1:0]  owner_d [N_PORT];
    logic [PTR_W-1:0]  rr_q    [N_PORT];
    logic [PTR_W-1:0]  rr_d    [N_PORT];
    logic              gate_err_q;
    logic              gate_err_d;

    logic [GATE_W-1:0] gate     [N_PORT];
    logic [N_PORT-1:0] elig     [N_PORT];
    logic [N_PORT-1:0] legal;
    logic [N_PORT-1:0] owns_any;
    logic [N_PORT-1:0] own_fire;
    logic [N_PORT-1:0] own_tail;

`ifdef ALLOC_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q [N_PORT];
    logic [CNT_W-1:0]  cnt_d [N_PORT];
`else
    logic [CNT_W-1:0]  unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT);
`endif

    // Decode the requests and gather each output owner's fire/tail and ownership flags.
    always_comb begin
        owns_any   = '0;
        own_fire   = '0;
        own_tail   = '0;
        legal      = '0;
        in_granted = '0;
        for (int i = 0; i < N_PORT; i++) begin
            gate[i]  = req_gate[GATE_W*i +: GATE_W];
            legal[i] = (gate[i] < GATE_W'(N_PORT));
        end
        for (int g = 0; g < N_PORT; g++) begin
            for (int i = 0; i < N_PORT; i++) begin
                if (owner_q[g] == SRC_W'(i)) begin
                    owns_any[i] = 1'b1;
                    own_fire[g] = in_fire[i];
                    own_tail[g] = req_tail[i];
                    if (req_valid[i] && (gate[i] == GATE_W'(g))) begin
                        in_granted[i] = 1'b1;
                    end
                end
            end
        end
        // Illegal gates never match g in 0..4, so those requests drop out here.
        for (int g = 0; g < N_PORT; g++) begin
            for (int i = 0; i < N_PORT; i++) begin
                elig[g][i] = req_valid[i] & (gate[i] == GATE_W'(g)) & ~owns_any[i];
            end
        end
    end

    // Next-state logic: arbitrate free outputs, release locked outputs on tail fire.
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand       = '0;
        owner_d    = owner_q;
        rr_d       = rr_q;
        gate_err_d = 1'b0;
`ifdef ALLOC_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        if (enable) begin
            gate_err_d = |(req_valid & ~legal);
            for (int g = 0; g < N_PORT; g++) begin
                if (owner_q[g] == IDLE_SRC) begin
                    // Scan from the farthest candidate down to the nearest one,
                    // so the first eligible input after the pointer is written last.
                    for (int k = N_PORT; k >= 1; k--) begin
                        cand = PTR_W'((int'(rr_q[g]) + k) % N_PORT);
                        if (elig[g][cand]) begin
                            owner_d[g] = SRC_W'(cand);
                            rr_d[g]    = cand;
                        end
                    end
                end else if (own_fire[g] && own_tail[g]) begin
                    owner_d[g] = IDLE_SRC;
                end
`ifdef ALLOC_TIMEOUT_EN
                // Idle-lock timer: cleared by any owner fire, frees the output on expiry.
                if (owner_q[g] == IDLE_SRC || own_fire[g]) begin
                    cnt_d[g] = '0;
                end else if (cnt_q[g] == CNT_W'(TIMEOUT - 1)) begin
                    cnt_d[g]   = '0;
                    owner_d[g] = IDLE_SRC;
                end else begin
                    cnt_d[g] = cnt_q[g] + CNT_W'(1);
                end
`endif
            end
        end
    end

    // State registers; reset drops every lock and points every search start at input 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < N_PORT; g++) begin
                owner_q[g] <= IDLE_SRC;
                rr_q[g]    <= PTR_W'(N_PORT - 1);
            end
            gate_err_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            gate_err_q <= gate_err_d;
        end
    end

`ifdef ALLOC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < N_PORT; g++) begin
                cnt_q[g] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ip_source    = owner_q[0];
    assign north_source = owner_q[1];
    assign south_source = owner_q[2];
    assign east_source  = owner_q[3];
    assign west_source  = owner_q[4];
    assign gate_err     = gate_err_q;

endmodule

// File: tb/tb_port_alloc_rr.sv
// -----------------------------------------------------------------------------
// tb_port_alloc_rr
//   Self-checking bench for port_alloc_rr. A behavioural model tracks the owner
//   of each output and the round-robin start point of each output. The model
//   is compared with the DUT on every falling edge. Directed scenarios add
//   literal expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_port_alloc_rr;

    localparam logic [3:0] F = 4'hf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [4:0]  req_valid;
    logic [14:0] req_gate;
    logic [4:0]  req_tail;
    logic [4:0]  in_fire;
    logic [3:0]  ip_source, north_source, south_source, east_source, west_source;
    logic [4:0]  in_granted;
    logic        gate_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    port_alloc_rr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_gate     (req_gate),
        .req_tail     (req_tail),
        .in_fire      (in_fire),
        .ip_source    (ip_source),
        .north_source (north_source),
        .south_source (south_source),
        .east_source  (east_source),
        .west_source  (west_source),
        .in_granted   (in_granted),
        .gate_err     (gate_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gate_of(input int i);
        return int'(req_gate[3*i +: 3]);
    endfunction

    // ---------------- behavioural model ----------------
    logic [3:0] m_own [5];
    int         m_ptr [5];
    int         m_cnt [5];
    logic       m_err;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] nxt [5];
        bit         busy [5];
        int         c, o;
        if (!rst_n) begin
            for (int g = 0; g < 5; g++) begin
                m_own[g] = F;
                m_ptr[g] = 4;
                m_cnt[g] = 0;
            end
            m_err = 1'b0;
        end else if (enable) begin
            for (int i = 0; i < 5; i++) busy[i] = 1'b0;
            for (int g = 0; g < 5; g++) if (m_own[g] != F) busy[m_own[g]] = 1'b1;
            m_err = 1'b0;
            for (int i = 0; i < 5; i++) if (req_valid[i] && gate_of(i) > 4) m_err = 1'b1;
            for (int g = 0; g < 5; g++) begin
                nxt[g] = m_own[g];
                if (m_own[g] == F) begin
                    for (int k = 1; k <= 5; k++) begin
                        c = (m_ptr[g] + k) % 5;
                        if (req_valid[c] && gate_of(c) == g && !busy[c]) begin
                            nxt[g]   = 4'(c);
                            m_ptr[g] = c;
                            break;
                        end
                    end
                end else begin
                    o = int'(m_own[g]);
                    if (in_fire[o]) begin
                        m_cnt[g] = 0;
                        if (req_tail[o]) nxt[g] = F;
                    end else begin
`ifdef ALLOC_TIMEOUT_EN
                        m_cnt[g] = m_cnt[g] + 1;
                        if (m_cnt[g] == 16) begin
                            nxt[g]   = F;
                            m_cnt[g] = 0;
                        end
`endif
                    end
                end
            end
            for (int g = 0; g < 5; g++) m_own[g] = nxt[g];
        end else begin
            m_err = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [4:0] m_g;
        if (chk_en) begin
            for (int i = 0; i < 5; i++)
                m_g[i] = req_valid[i] && gate_of(i) <= 4 && m_own[gate_of(i)] == 4'(i);
            check("ip_source",    ip_source,    m_own[0]);
            check("north_source", north_source, m_own[1]);
            check("south_source", south_source, m_own[2]);
            check("east_source",  east_source,  m_own[3]);
            check("west_source",  west_source,  m_own[4]);
            check("in_granted",   in_granted,   m_g);
            check("gate_err",     gate_err,     m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
        req_gate  = '0;
        req_tail  = '0;
        in_fire   = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq [7];
        seq = '{0, 15, 2, 15, 4, 15, 0};
        rst_n  = 1'b1;
        enable = 1'b0;
        clr();
        #2 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        chk_en = 1'b1;

        // Idle after reset.
        for (int n = 0; n < 10; n++) begin
            cyc();
            check("idle_sources", {ip_source, north_source, south_source, east_source, west_source}, 20'hfffff);
            check("idle_granted", in_granted, 5'b0);
        end

        // Input 1 asks for east.
        req_valid = 5'b00010;
        req_gate  = 15'(3 << 3);
        cyc();
        check("east_grant", east_source, 4'h1);
        check("east_in_granted", in_granted, 5'b00010);
        in_fire  = 5'b00010;
        req_tail = 5'b00010;
        cyc();
        check("east_release", east_source, F);
        clr();

        // Inputs 0,2,4 contend for west; each grant ends with its tail.
        req_valid = 5'b10101;
        req_gate  = {3'd4, 3'd0, 3'd4, 3'd0, 3'd4};
        req_tail  = 5'h1f;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check("west_seq", west_source, seq[k]);
            in_fire = (seq[k] != 15) ? 5'(1 << seq[k]) : 5'b0;
        end
        req_valid = '0;
        cyc();
        check("west_final_release", west_source, F);
        clr();

        // South handover from input 2 to input 3 with one bubble.
        req_valid = 5'b00100;
        req_gate  = 15'(2 << 6);
        cyc();
        check("south_own2", south_source, 4'h2);
        req_valid = 5'b01100;
        req_gate  = 15'((2 << 9) | (2 << 6));
        in_fire   = 5'b00100;
        req_tail  = 5'b00100;
        cyc();
        check("south_bubble", south_source, F);
        in_fire   = '0;
        req_tail  = '0;
        req_valid = 5'b01000;
        cyc();
        check("south_own3", south_source, 4'h3);
        in_fire  = 5'b01000;
        req_tail = 5'b01000;
        cyc();
        clr();

        // Illegal gate request.
        req_valid = 5'b00001;
        req_gate  = 15'd6;
        cyc();
        check("gate_err_pulse", gate_err, 1'b1);
        check("gate_err_no_owner", {ip_source, north_source, south_source, east_source, west_source}, 20'hfffff);
        clr();
        cyc();
        check("gate_err_clear", gate_err, 1'b0);

        // Async reset mid-packet drops the lock immediately.
        req_valid = 5'b10000;
        req_gate  = 15'(1 << 12);
        cyc();
        check("north_own4", north_source, 4'h4);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_north", north_source, F);
        check("async_reset_granted", in_granted, 5'b0);
        clr();
        @(negedge clk);
        rst_n = 1'b1;

        // enable low holds the lock through a tail fire.
        req_valid = 5'b00001;
        req_gate  = 15'd0;
        cyc();
        check("ip_own0", ip_source, 4'h0);
        enable   = 1'b0;
        in_fire  = 5'b00001;
        req_tail = 5'b00001;
        cyc();
        check("enable_hold", ip_source, 4'h0);
        enable = 1'b1;
        cyc();
        check("enable_release", ip_source, F);
        clr();

`ifdef ALLOC_TIMEOUT_EN
        // Idle lock expires 16 cycles after being taken.
        req_valid = 5'b00001;
        cyc();
        check("to_lock", ip_source, 4'h0);
        req_valid = '0;
        repeat (15) cyc();
        check("to_still_locked", ip_source, 4'h0);
        cyc();
        check("to_expired", ip_source, F);
        clr();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(0, 9) != 0);
            req_valid = 5'($urandom);
            for (int i = 0; i < 5; i++)
                req_gate[3*i +: 3] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                                 : 3'($urandom_range(0, 4));
            for (int i = 0; i < 5; i++) req_tail[i] = ($urandom_range(0, 2) == 0);
            in_fire = 5'($urandom);
            if (n == 1500) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
